// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: command encoding, FSM states and FIFO entry layout.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   typedef enum logic [1:0] {
      CMD_MEM    = 2'b00,
      CMD_ALU    = 2'b01,
      CMD_BRANCH = 2'b10,
      CMD_OTHER  = 2'b11
   } cmd_type_t;

   typedef enum logic {
      RUN      = 1'b0,
      WAIT_LMD = 1'b1
   } wb_state_t;

   typedef struct packed {
      cmd_type_t              cmd_type;
      logic                   is_load;
      logic [WB_DATA_W-1:0]   alu_result;
      logic [WB_REG_AW-1:0]   reg_dst;
   } wb_entry_t;

   // A memory command only waits for load data when it is actually a load.
   function automatic logic entry_is_load(input wb_entry_t e);
      return (e.cmd_type == CMD_MEM) && e.is_load;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO; pointers carry one extra bit so full and empty are distinguishable.
module wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; push while full is only legal together with a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: buffers retired instructions, pairs loads with returning memory
// data and drives a single registered register-file write port.
module wb_stage
   import wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_cmd_type,
   input  logic              in_is_load,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [REG_AW-1:0] in_reg_dst,
   input  logic              lmd_valid,
   input  logic [DATA_W-1:0] lmd_data,
   output logic [DATA_W-1:0] ALU_output,
   output logic [DATA_W-1:0] LMD_output,
   output logic [REG_AW-1:0] reg_dst,
   output logic              alu_write,
   output logic              mem_write,
   output logic [31:0]       retired_count,
   output logic              lmd_err,
   output logic              busy
);

   wb_state_t state;
   wb_state_t next_state;
   wb_entry_t push_entry;
   wb_entry_t head;
   logic      full;
   logic      empty;
   logic      push;
   logic      pop;
   logic      drop;
   logic      head_load;

   assign push_entry = '{cmd_type:   cmd_type_t'(in_cmd_type),
                         is_load:    in_is_load,
                         alu_result: in_alu_result,
                         reg_dst:    in_reg_dst};

   assign head_load = !empty && entry_is_load(head);
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready && !rst;
   assign busy      = !empty || (state == WAIT_LMD);

   wb_fifo #(
      .WIDTH ($bits(wb_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // Head-of-queue decision: pop, wait for load data, or flag stray load data.
   always_comb begin
      pop        = 1'b0;
      drop       = 1'b0;
      next_state = state;
      if (rst) begin
         next_state = RUN;
      end else begin
         case (state)
            RUN: begin
               if (empty) begin
                  drop = lmd_valid;
               end else if (head_load) begin
                  if (lmd_valid) begin
                     pop = 1'b1;
                  end else begin
                     next_state = WAIT_LMD;
                  end
               end else begin
                  pop  = 1'b1;
                  drop = lmd_valid;
               end
            end
            WAIT_LMD: begin
               if (lmd_valid) begin
                  pop        = 1'b1;
                  next_state = RUN;
               end else begin
                  next_state = WAIT_LMD;
               end
            end
            default: begin
               next_state = RUN;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Registered write port, retire counter and sticky stray-data flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_write     <= 1'b0;
         mem_write     <= 1'b0;
         ALU_output    <= '0;
         LMD_output    <= '0;
         reg_dst       <= '0;
         retired_count <= 32'd0;
         lmd_err       <= 1'b0;
      end else begin
         alu_write <= 1'b0;
         mem_write <= 1'b0;
         if (pop) begin
            retired_count <= retired_count + 32'd1;
            if (head.reg_dst != '0) begin
               case (head.cmd_type)
                  CMD_ALU: begin
                     alu_write  <= 1'b1;
                     ALU_output <= head.alu_result;
                     reg_dst    <= head.reg_dst;
                  end
                  CMD_MEM: begin
                     if (head.is_load) begin
                        mem_write  <= 1'b1;
                        LMD_output <= lmd_data;
                        reg_dst    <= head.reg_dst;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
         if (drop) begin
            lmd_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations plus
// a randomized run compared every cycle against a queue-based behavioural model.
module tb_wb_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_cmd_type = 2'b00;
   logic        in_is_load = 1'b0;
   logic [31:0] in_alu_result = 32'd0;
   logic [4:0]  in_reg_dst = 5'd0;
   logic        lmd_valid = 1'b0;
   logic [31:0] lmd_data = 32'd0;
   logic [31:0] ALU_output;
   logic [31:0] LMD_output;
   logic [4:0]  reg_dst;
   logic        alu_write;
   logic        mem_write;
   logic [31:0] retired_count;
   logic        lmd_err;
   logic        busy;

   int checks = 0;
   int failures = 0;

   wb_stage #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_cmd_type   (in_cmd_type),
      .in_is_load    (in_is_load),
      .in_alu_result (in_alu_result),
      .in_reg_dst    (in_reg_dst),
      .lmd_valid     (lmd_valid),
      .lmd_data      (lmd_data),
      .ALU_output    (ALU_output),
      .LMD_output    (LMD_output),
      .reg_dst       (reg_dst),
      .alu_write     (alu_write),
      .mem_write     (mem_write),
      .retired_count (retired_count),
      .lmd_err       (lmd_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [1:0]  cmd;
      logic        ld;
      logic [31:0] res;
      logic [4:0]  dst;
   } ent_t;

   ent_t        q[$];
   logic        model_live = 1'b0;
   logic        m_alu_w = 1'b0;
   logic        m_mem_w = 1'b0;
   logic [31:0] m_alu_out = 32'd0;
   logic [31:0] m_lmd_out = 32'd0;
   logic [4:0]  m_dst = 5'd0;
   logic [31:0] m_ret = 32'd0;
   logic        m_err = 1'b0;

   function automatic logic m_head_load();
      return (q.size() > 0) && (q[0].cmd == 2'b00) && q[0].ld;
   endfunction

   function automatic logic m_pop();
      return (q.size() > 0) && (!m_head_load() || lmd_valid);
   endfunction

   // Model advance: the head retires when it is not a load or its data is present.
   always @(posedge clk) begin
      logic hl;
      logic pp;
      logic rdy;
      ent_t e;
      if (rst) begin
         q.delete();
         m_alu_w = 1'b0; m_mem_w = 1'b0;
         m_alu_out = 32'd0; m_lmd_out = 32'd0; m_dst = 5'd0;
         m_ret = 32'd0; m_err = 1'b0;
         model_live = 1'b1;
      end else begin
         hl  = m_head_load();
         pp  = m_pop();
         rdy = (q.size() < DEPTH) || pp;
         if (lmd_valid && !hl) m_err = 1'b1;
         m_alu_w = 1'b0;
         m_mem_w = 1'b0;
         if (pp) begin
            e = q.pop_front();
            m_ret = m_ret + 32'd1;
            if (e.dst != 5'd0) begin
               if (e.cmd == 2'b01) begin
                  m_alu_w = 1'b1; m_alu_out = e.res; m_dst = e.dst;
               end else if (hl) begin
                  m_mem_w = 1'b1; m_lmd_out = lmd_data; m_dst = e.dst;
               end
            end
         end
         if (in_valid && rdy) begin
            e.cmd = in_cmd_type; e.ld = in_is_load; e.res = in_alu_result; e.dst = in_reg_dst;
            q.push_back(e);
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      if (model_live) begin
         if (!rst) chk("m_in_ready", 32'(in_ready), 32'((q.size() < DEPTH) || m_pop()));
         chk("m_alu_write", 32'(alu_write), 32'(m_alu_w));
         chk("m_mem_write", 32'(mem_write), 32'(m_mem_w));
         chk("m_ALU_output", ALU_output, m_alu_out);
         chk("m_LMD_output", LMD_output, m_lmd_out);
         chk("m_reg_dst", 32'(reg_dst), 32'(m_dst));
         chk("m_retired", retired_count, m_ret);
         chk("m_lmd_err", 32'(lmd_err), 32'(m_err));
         chk("m_busy", 32'(busy), 32'(q.size() > 0));
         chk("m_excl", 32'(alu_write && mem_write), 32'd0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      lmd_valid = 1'b0;
   endtask

   task automatic drive(input logic [1:0] c, input logic ld, input logic [4:0] d, input logic [31:0] r);
      in_valid = 1'b1; in_cmd_type = c; in_is_load = ld; in_reg_dst = d; in_alu_result = r;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // ALU stream: two back-to-back ALU writes.
      drive(2'b01, 1'b0, 5'd5, 32'h12); step();
      drive(2'b01, 1'b0, 5'd6, 32'h34); step();
      idle();
      @(negedge clk);
      chk("alu1_strobe", 32'(alu_write), 32'd1);
      chk("alu1_dst", 32'(reg_dst), 32'd5);
      chk("alu1_data", ALU_output, 32'h12);
      step();
      @(negedge clk);
      chk("alu2_strobe", 32'(alu_write), 32'd1);
      chk("alu2_dst", 32'(reg_dst), 32'd6);
      chk("alu2_data", ALU_output, 32'h34);
      chk("alu_retired", retired_count, 32'd2);
      step();
      @(negedge clk);
      chk("alu_end_strobe", 32'(alu_write), 32'd0);

      // Load waiting three cycles for its data.
      do_reset();
      drive(2'b00, 1'b1, 5'd7, 32'h0); step();
      idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ldw_busy", 32'(busy), 32'd1);
         chk("ldw_no_write", 32'(mem_write), 32'd0);
         step();
      end
      lmd_valid = 1'b1; lmd_data = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("ldw_busy_pulse", 32'(busy), 32'd1);
      step();
      idle();
      @(negedge clk);
      chk("ldw_strobe", 32'(mem_write), 32'd1);
      chk("ldw_dst", 32'(reg_dst), 32'd7);
      chk("ldw_data", LMD_output, 32'hDEAD_BEEF);
      chk("ldw_idle", 32'(busy), 32'd0);
      step();
      @(negedge clk);
      chk("ldw_single", 32'(mem_write), 32'd0);

      // Backpressure with a full FIFO, then pop and push in one cycle.
      do_reset();
      drive(2'b00, 1'b1, 5'd10, 32'h0); step();
      drive(2'b01, 1'b0, 5'd8, 32'h1); step();
      drive(2'b01, 1'b0, 5'd9, 32'h2);
      @(negedge clk);
      chk("bp_not_ready", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("bp_still_not_ready", 32'(in_ready), 32'd0);
      lmd_valid = 1'b1; lmd_data = 32'h55;
      #1;
      chk("bp_ready_on_pop", 32'(in_ready), 32'd1);
      step();
      idle();
      @(negedge clk);
      chk("bp_ld_strobe", 32'(mem_write), 32'd1);
      chk("bp_ld_dst", 32'(reg_dst), 32'd10);
      chk("bp_ld_data", LMD_output, 32'h55);
      step();
      @(negedge clk);
      chk("bp_alu8", 32'(alu_write), 32'd1);
      chk("bp_alu8_dst", 32'(reg_dst), 32'd8);
      step();
      @(negedge clk);
      chk("bp_alu9_dst", 32'(reg_dst), 32'd9);
      chk("bp_alu9_data", ALU_output, 32'h2);
      chk("bp_retired", retired_count, 32'd3);

      // r0 write and non-writing commands.
      do_reset();
      drive(2'b01, 1'b0, 5'd0, 32'h99); step();
      drive(2'b00, 1'b0, 5'd4, 32'h44); step();
      drive(2'b10, 1'b0, 5'd5, 32'h55); step();
      idle();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("r0_no_strobe", 32'(alu_write || mem_write), 32'd0);
         step();
      end
      @(negedge clk);
      chk("r0_alu_out", ALU_output, 32'd0);
      chk("r0_retired", retired_count, 32'd3);

      // Stray load data, then reset in WAIT_LMD.
      do_reset();
      lmd_valid = 1'b1; lmd_data = 32'h1234;
      step();
      lmd_valid = 1'b0;
      @(negedge clk);
      chk("err_set", 32'(lmd_err), 32'd1);
      drive(2'b00, 1'b1, 5'd3, 32'h0); step();
      idle(); step();
      @(negedge clk);
      chk("rst_wait_busy", 32'(busy), 32'd1);
      rst = 1'b1; lmd_valid = 1'b1; lmd_data = 32'h77;
      step();
      rst = 1'b0; lmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_all_zero", {ALU_output[7:0], LMD_output[7:0], 3'd0, reg_dst,
                           2'd0, alu_write, mem_write, lmd_err, busy, 2'd0}, 32'd0);
      chk("rst_retired", retired_count, 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      lmd_valid = 1'b1; lmd_data = 32'h88;
      step();
      lmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_no_write", 32'(mem_write), 32'd0);
      chk("rst_err_again", 32'(lmd_err), 32'd1);

      // Randomized traffic checked by the model.
      for (int i = 0; i < 3000; i++) begin
         in_valid      = ($urandom_range(0, 9) < 6);
         in_cmd_type   = 2'($urandom_range(0, 3));
         in_is_load    = 1'($urandom_range(0, 1));
         in_reg_dst    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         in_alu_result = $urandom;
         lmd_valid     = ($urandom_range(0, 9) < 4);
         lmd_data      = $urandom;
         rst           = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      step();
      step();
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
